// File: rtl/nbout_psum_ctrl.sv
// Output-neuron buffer controller: feeds stored partial sums to NFU-2, writes results back, forwards last-pass sums.
// Psum valid one cycle after accept; o_out_data held in DRAIN until i_out_ready; no new pass is accepted outside IDLE.
module nbout_psum_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int DEPTH     = 8,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int DW       = BIT_WIDTH * Tn
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_tile_idx,
    input  logic             i_first,
    input  logic             i_last,
    output logic             o_ready,
    output logic [DW-1:0]    o_partial_sum,
    output logic             o_psum_valid,
    input  logic             i_nfu2_valid,
    input  logic [DW-1:0]    i_nfu2_out,
    output logic [DW-1:0]    o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             complete;
    logic             drain_done;

    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic [DW-1:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        complete   = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_nfu2_valid) begin
                    complete  = 1'b1;
                    state_nxt = last_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (i_out_ready) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);

    // The partial sum is captured at accept, so it cannot shift while NFU-2 is working on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            last_q        <= 1'b0;
            o_partial_sum <= '0;
            o_psum_valid  <= 1'b0;
            o_out_data    <= '0;
            o_out_valid   <= 1'b0;
        end else begin
            if (accept) begin
                idx_q         <= i_tile_idx;
                last_q        <= i_last;
                o_partial_sum <= i_first ? '0 : mem[i_tile_idx];
                o_psum_valid  <= 1'b1;
            end
            if (complete) begin
                o_psum_valid <= 1'b0;
                if (last_q) begin
                    o_out_data  <= i_nfu2_out;
                    o_out_valid <= 1'b1;
                end
            end
            if (drain_done) begin
                o_out_valid <= 1'b0;
            end
        end
    end

    // Tile storage survives reset; a reset edge must still block a pending write-back.
    always_ff @(posedge clk) begin
        if (!rst && complete) begin
            mem[idx_q] <= i_nfu2_out;
        end
    end

endmodule
